// File: rtl/sync_arith_pkg.sv
// Shared types for the multi-cycle arithmetic unit:
// opcodes, FSM states and status flag positions.
package sync_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam int ST_ZERO  = 0;
    localparam int ST_NEG   = 1;
    localparam int ST_CARRY = 2;
    localparam int ST_ERR   = 3;

    function automatic logic [3:0] pack_status(
        input logic zero,
        input logic neg,
        input logic carry,
        input logic err
    );
        logic [3:0] s;
        s = '0;
        s[ST_ZERO]  = zero;
        s[ST_NEG]   = neg;
        s[ST_CARRY] = carry;
        s[ST_ERR]   = err;
        return s;
    endfunction

endpackage

// File: rtl/sync_arith_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide,
// one step per cycle, with the shared iteration counter.
module sync_arith_iter_core
    import sync_arith_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic              iterative,
    input  logic [BITS-1:0]   a,
    input  logic [BITS-1:0]   b,
    output logic              last,
    output logic [2*BITS-1:0] prod,
    output logic [BITS-1:0]   quot
);

    localparam int CW = $clog2(BITS + 1);

    logic [2*BITS-1:0] acc;
    logic [2*BITS-1:0] mcand;
    logic [BITS-1:0]   shreg;
    logic [BITS-1:0]   rem;
    logic              div_mode;
    logic [CW-1:0]     cnt;

    logic [BITS:0]     rem_sh;
    logic [BITS-1:0]   rem_sub;
    logic              ge;

    // Divide: the divisor sits in mcand's low half, which never shifts there.
    assign rem_sh  = {rem, shreg[BITS-1]};
    assign ge      = rem_sh >= {1'b0, mcand[BITS-1:0]};
    assign rem_sub = rem_sh[BITS-1:0] - mcand[BITS-1:0];

    // Outputs are the values after the current step, so the top can
    // register the final result on the same edge the last step happens.
    assign prod = shreg[0] ? acc + mcand : acc;
    assign quot = {shreg[BITS-2:0], ge};
    assign last = cnt == CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            mcand    <= '0;
            shreg    <= '0;
            rem      <= '0;
            div_mode <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            acc      <= '0;
            mcand    <= {{BITS{1'b0}}, b};
            shreg    <= a;
            rem      <= '0;
            div_mode <= is_div;
            cnt      <= iterative ? CW'(BITS) : CW'(1);
        end else if (step) begin
            cnt <= cnt - CW'(1);
            if (div_mode) begin
                rem   <= ge ? rem_sub : rem_sh[BITS-1:0];
                shreg <= quot;
            end else begin
                acc   <= prod;
                mcand <= mcand << 1;
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: rtl/sync_arith_unit_mc.sv
// Multi-cycle arithmetic unit: ADD/SUB in one step, MUL/DIV iterative,
// with an IDLE/EXEC/DONE handshake FSM and registered result flags.
module sync_arith_unit_mc
    import sync_arith_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    output logic [BITS-1:0] o_result,
    output logic [3:0]      o_status,
    output logic            o_valid
);

    state_e          state;
    op_e             op_q;
    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;

    logic              accept;
    logic              in_is_div;
    logic              in_iter;
    logic              iter_last;
    logic [2*BITS-1:0] prod;
    logic [BITS-1:0]   quot;

    logic [BITS:0]   sum;
    logic [BITS-1:0] res;
    logic            carry;
    logic            err;

    assign accept    = (state == S_IDLE) && i_valid;
    assign in_is_div = i_op == OP_DIV;
    // Divide by zero short-circuits to a single EXEC cycle.
    assign in_iter   = (i_op == OP_MUL) || (in_is_div && i_arg_B != '0);

    sync_arith_iter_core #(
        .BITS(BITS)
    ) u_core (
        .clk       (i_clk),
        .reset     (i_reset),
        .load      (accept),
        .step      (state == S_EXEC),
        .is_div    (in_is_div),
        .iterative (in_iter),
        .a         (i_arg_A),
        .b         (i_arg_B),
        .last      (iter_last),
        .prod      (prod),
        .quot      (quot)
    );

    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        res   = '0;
        carry = 1'b0;
        err   = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                res   = sum[BITS-1:0];
                carry = sum[BITS];
            end
            OP_SUB: begin
                res   = a_q - b_q;
                carry = a_q < b_q;
            end
            OP_MUL: begin
                res   = prod[BITS-1:0];
                carry = |prod[2*BITS-1:BITS];
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res = '1;
                    err = 1'b1;
                end else begin
                    res = quot;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_status <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    o_valid <= 1'b0;
                    if (i_valid) begin
                        op_q    <= op_e'(i_op);
                        a_q     <= i_arg_A;
                        b_q     <= i_arg_B;
                        o_ready <= 1'b0;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (iter_last) begin
                        o_result <= res;
                        o_status <= pack_status(res == '0, res[BITS-1],
                                                carry, err);
                        o_valid  <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_arith_unit_mc.sv
// Scoreboard bench for sync_arith_unit_mc at BITS=8: directed corner
// cases, a mid-operation reset, back-to-back requests and random traffic.
module tb_sync_arith_unit_mc;

    localparam int BITS = 8;
    localparam int LIMIT = 100;

    logic            clk = 1'b0;
    logic            rst;
    logic            vld;
    logic            rdy;
    logic [1:0]      op;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] res;
    logic [3:0]      st;
    logic            ov;

    sync_arith_unit_mc #(
        .BITS(BITS)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_valid  (vld),
        .o_ready  (rdy),
        .i_op     (op),
        .i_arg_A  (a),
        .i_arg_B  (b),
        .o_result (res),
        .o_status (st),
        .o_valid  (ov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [BITS-1:0] r;
        logic [3:0]      s;
        int              due;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad = 0;
    logic [BITS-1:0] hold_r = '0;
    logic [3:0]      hold_s = '0;
    bit              mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model from the arithmetic definitions; due = latency.
    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int   m;
        int   r;
        int   c;
        int   er;
        m  = 1 << BITS;
        c  = 0;
        er = 0;
        e.due = 1;
        case (o)
            0: begin
                r = (x + y) % m;
                c = (x + y >= m) ? 1 : 0;
            end
            1: begin
                r = (x - y + m) % m;
                c = (x < y) ? 1 : 0;
            end
            2: begin
                r = (x * y) % m;
                c = (x * y >= m) ? 1 : 0;
                e.due = BITS;
            end
            default: begin
                if (y == 0) begin
                    r  = m - 1;
                    er = 1;
                end else begin
                    r = x / y;
                    e.due = BITS;
                end
            end
        endcase
        e.r = BITS'(r);
        e.s = {er[0], c[0], (r >= m / 2), (r == 0)};
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (ov) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(ov), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 32'(res), 32'(e.r));
                    chk("status", 32'(st), 32'(e.s));
                    chk("latency_edge", cyc, e.due);
                    hold_r = e.r;
                    hold_s = e.s;
                end
            end else begin
                chk("hold_result", 32'(res), 32'(hold_r));
                chk("hold_status", 32'(st), 32'(hold_s));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input int o, input int x, input int y,
                         input bit hold);
        int   n;
        exp_t e;
        n = 0;
        while (!rdy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < LIMIT), 32'd1);
        op  = 2'(o);
        a   = BITS'(x);
        b   = BITS'(y);
        vld = 1'b1;
        e = model(o, x, y);
        e.due = cyc + 1 + e.due;
        sb.push_back(e);
        @(negedge clk);
        chk("busy_ready", 32'(rdy), 32'd0);
        vld = hold;
        op  = 2'($urandom);
        a   = BITS'($urandom);
        b   = BITS'($urandom);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        vld = 1'b0;
        op  = '0;
        a   = '0;
        b   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(rdy), 32'd1);
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_result", 32'(res), 32'd0);
        chk("rst_status", 32'(st), 32'd0);
        mon_en = 1'b1;

        issue(0, 8'hFF, 8'h01, 1'b0);
        issue(1, 8'h05, 8'h07, 1'b0);
        issue(2, 8'h10, 8'h10, 1'b0);
        issue(2, 8'h0C, 8'h0A, 1'b0);
        issue(3, 8'hC8, 8'h07, 1'b0);
        issue(3, 8'h33, 8'h00, 1'b0);
        issue(3, 8'h00, 8'h05, 1'b0);
        issue(2, 8'hFF, 8'hFF, 1'b0);

        // Reset lands on edge k+4 of an in-flight MUL with a request pending.
        issue(2, 8'h37, 8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        vld = 1'b1;
        op  = 2'd0;
        sb.delete();
        hold_r = '0;
        hold_s = '0;
        @(negedge clk);
        rst = 1'b0;
        vld = 1'b0;
        chk("abort_ready", 32'(rdy), 32'd1);
        chk("abort_valid", 32'(ov), 32'd0);
        chk("abort_result", 32'(res), 32'd0);
        chk("abort_status", 32'(st), 32'd0);
        issue(0, 8'h01, 8'h02, 1'b0);

        // i_valid held high across three requests.
        issue(0, 8'h10, 8'h20, 1'b1);
        issue(2, 8'h07, 8'h09, 1'b1);
        issue(3, 8'hF0, 8'h0F, 1'b0);

        for (int i = 0; i < 200; i++) begin
            int o;
            int x;
            int y;
            o = int'($urandom_range(3, 0));
            x = int'($urandom_range(255, 0));
            y = int'($urandom_range(255, 0));
            if ($urandom_range(7, 0) == 0) y = 0;
            if ($urandom_range(7, 0) == 0) x = 255;
            issue(o, x, y, $urandom_range(1, 0) == 1);
            if ($urandom_range(3, 0) == 0) begin
                vld = 1'b0;
                repeat (int'($urandom_range(3, 1))) @(negedge clk);
            end
        end
        vld = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("drain", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
